// File: rtl/dffram_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dffram_wb_pkg
// Description : Shared types, constants and address-decode helper for the
//               Wishbone-to-DFFRAM adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package dffram_wb_pkg;

   localparam int WORD_BYTES = 4;
   localparam int DATA_W     = 32;

   // RD_REG is only reachable when the registered read path is built in.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_DATA = 3'd1,
      RD_REG  = 3'd2,
      ACK     = 3'd3,
      ERR     = 3'd4
   } wb_state_t;

   // Window hit: every address bit above the word index must match the base.
   function automatic logic addr_hit(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input int unsigned aw);
      return (adr >> (aw + 2)) == (base >> (aw + 2));
   endfunction

endpackage
`default_nettype wire

// File: rtl/dffram_wb_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : dffram_wb_adapter_if
// Description : Wishbone-classic bus bundle between a master and the
//               DFFRAM adapter slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface dffram_wb_adapter_if
   import dffram_wb_pkg::*;
#(
   parameter int WSIZE = 4
);
   logic              wb_cyc_i;
   logic              wb_stb_i;
   logic              wb_we_i;
   logic [WSIZE-1:0]  wb_sel_i;
   logic [31:0]       wb_adr_i;
   logic [DATA_W-1:0] wb_dat_i;
   logic [DATA_W-1:0] wb_dat_o;
   logic              wb_ack_o;
   logic              wb_err_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface
`default_nettype wire

// File: rtl/dffram_wb_addr_dec.sv
`default_nettype none
// ============================================================================
// Module      : dffram_wb_addr_dec
// Description : Combinational window decode: hit flag and RAM word index
//               from a Wishbone byte address. Byte offset bits are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module dffram_wb_addr_dec
   import dffram_wb_pkg::*;
#(
   parameter int          AW        = 9,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  wire logic [31:0]   i_adr,
   output logic               o_hit,
   output logic [AW-1:0]      o_ram_a0
);

   assign o_hit    = addr_hit(i_adr, BASE_ADDR, AW);
   assign o_ram_a0 = i_adr[AW+1:2];

endmodule
`default_nettype wire

// File: rtl/dffram_wb_adapter.sv
`default_nettype none
// ============================================================================
// Module      : dffram_wb_adapter
// Description : Wishbone-classic slave driving a single-port DFFRAM macro.
//               Handles decode, byte-lane enables, read latency, ack/err.
//               Build option DFFRAM_WB_READ_REG_EN adds a read data register
//               (RD_REG state), giving 2-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module dffram_wb_adapter
   import dffram_wb_pkg::*;
#(
   parameter int          AW        = 9,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          WSIZE     = 4
) (
   input  wire logic              CLK,
   input  wire logic              RST,
   dffram_wb_adapter_if.slave     wb,
   output logic                   ram_en0,
   output logic [WSIZE-1:0]       ram_we0,
   output logic [AW-1:0]          ram_a0,
   output logic [DATA_W-1:0]      ram_di0,
   input  wire logic [DATA_W-1:0] ram_do0
);

   wb_state_t     r_state;
   wb_state_t     w_next;
   logic          w_req;
   logic          w_hit;
   logic [AW-1:0] w_a0;

   dffram_wb_addr_dec #(
      .AW        (AW),
      .BASE_ADDR (BASE_ADDR)
   ) u_addr_dec (
      .i_adr    (wb.wb_adr_i),
      .o_hit    (w_hit),
      .o_ram_a0 (w_a0)
   );

   assign w_req   = wb.wb_cyc_i & wb.wb_stb_i;
   assign ram_a0  = w_a0;
   assign ram_di0 = wb.wb_dat_i;

   // State register; reset returns to IDLE regardless of bus activity.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end

`ifdef DFFRAM_WB_READ_REG_EN
   logic [DATA_W-1:0] r_rd_data;

   // Capture RAM output in RD_DATA; clear on any abort so stale data never leaks.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         r_rd_data <= '0;
      else if ((r_state == RD_DATA || r_state == RD_REG) && !wb.wb_cyc_i)
         r_rd_data <= '0;
      else if (r_state == RD_DATA)
         r_rd_data <= ram_do0;
   end
`endif

   // Next state, RAM strobes and bus responses; reset gates every output at once.
   always_comb begin
      w_next      = r_state;
      ram_en0     = 1'b0;
      ram_we0     = '0;
      wb.wb_ack_o = 1'b0;
      wb.wb_err_o = 1'b0;
      wb.wb_dat_o = '0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               if (!w_hit) begin
                  w_next = ERR;
               end else if (wb.wb_we_i) begin
                  // A write with no lanes selected still acks but never touches the RAM.
                  ram_en0 = |wb.wb_sel_i;
                  ram_we0 = wb.wb_sel_i;
                  w_next  = ACK;
               end else begin
                  ram_en0 = 1'b1;
                  w_next  = RD_DATA;
               end
            end
         end
         RD_DATA: begin
            w_next = IDLE;
`ifdef DFFRAM_WB_READ_REG_EN
            if (wb.wb_cyc_i) w_next = RD_REG;
`else
            if (wb.wb_cyc_i) begin
               wb.wb_ack_o = 1'b1;
               wb.wb_dat_o = ram_do0;
            end
`endif
         end
`ifdef DFFRAM_WB_READ_REG_EN
         RD_REG: begin
            w_next = IDLE;
            if (wb.wb_cyc_i) begin
               wb.wb_ack_o = 1'b1;
               wb.wb_dat_o = r_rd_data;
            end
         end
`endif
         ACK: begin
            w_next      = IDLE;
            wb.wb_ack_o = wb.wb_cyc_i;
         end
         ERR: begin
            w_next      = IDLE;
            wb.wb_err_o = wb.wb_cyc_i;
         end
         default: w_next = IDLE;
      endcase
      if (RST) begin
         ram_en0     = 1'b0;
         ram_we0     = '0;
         wb.wb_ack_o = 1'b0;
         wb.wb_err_o = 1'b0;
         wb.wb_dat_o = '0;
      end
   end

endmodule
`default_nettype wire
